// File: rtl/decode_regfile.sv
// decode_regfile: RV32I decode, 32x32 register file, retired counter and sticky illegal flag
module decode_regfile #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int AW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instruction,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [AW-1:0]   rd,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      alu_ctrl,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jump,
  output logic            alu_src,
  output logic            illegal,
  output logic            illegal_seen,
  output logic [31:0]     instr_count
);
  logic [XLEN-1:0] regs [NREGS];
  logic [6:0] op;
  logic [2:0] f3;
  logic [AW-1:0] a1, a2;
  logic r_t, i_t, ld_t, st_t, br_t, jal_t, jalr_t, lui_t, aui_t;
  assign op = instruction[6:0];
  assign f3 = instruction[14:12];
  assign a1 = instruction[19:15];
  assign a2 = instruction[24:20];
  assign rd = instruction[11:7];
  assign rs1_data = a1 == '0 ? '0 : regs[a1];
  assign rs2_data = a2 == '0 ? '0 : regs[a2];
  assign r_t = op == 7'b0110011;
  assign i_t = op == 7'b0010011;
  assign ld_t = op == 7'b0000011;
  assign st_t = op == 7'b0100011;
  assign br_t = op == 7'b1100011;
  assign jal_t = op == 7'b1101111;
  assign jalr_t = op == 7'b1100111;
  assign lui_t = op == 7'b0110111;
  assign aui_t = op == 7'b0010111;
  assign illegal = !(r_t | i_t | ld_t | st_t | br_t | jal_t | jalr_t | lui_t | aui_t);
  assign reg_write = r_t | i_t | ld_t | jal_t | jalr_t | lui_t | aui_t;
  assign alu_src = i_t | ld_t | st_t | jal_t | jalr_t | lui_t | aui_t;
  assign mem_read = ld_t;
  assign mem_write = st_t;
  assign branch = br_t;
  assign jump = jal_t | jalr_t;
  always_comb begin
    alu_ctrl = r_t ? {instruction[30], f3} :
               i_t ? {instruction[30] & (f3 == 3'b101), f3} :
               br_t ? 4'b1000 : 4'b0000;
    imm = (i_t | ld_t | jalr_t) ? {{20{instruction[31]}}, instruction[31:20]} :
          st_t ? {{20{instruction[31]}}, instruction[31:25], instruction[11:7]} :
          br_t ? {{20{instruction[31]}}, instruction[7], instruction[30:25], instruction[11:8], 1'b0} :
          (lui_t | aui_t) ? {instruction[31:12], 12'b0} :
          jal_t ? {{12{instruction[31]}}, instruction[19:12], instruction[20], instruction[30:21], 1'b0} :
          '0;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      instr_count <= '0;
      illegal_seen <= 1'b0;
    end else begin
      if (wb_en && wb_addr != '0) regs[wb_addr] <= wb_data;
      if (!illegal) instr_count <= instr_count + 32'd1;
      if (illegal) illegal_seen <= 1'b1;
    end
endmodule

// File: tb/tb_decode_regfile.sv
// tb_decode_regfile: scoreboard-driven checks of decode, register file, counter and illegal flag
module tb_decode_regfile;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] instruction = 32'h00000013;
  logic wb_en = 1'b0;
  logic [4:0] wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [31:0] rs1_data, rs2_data, imm, instr_count;
  logic [4:0] rd;
  logic [3:0] alu_ctrl;
  logic reg_write, mem_read, mem_write, branch, jump, alu_src, illegal, illegal_seen;
  logic [10:0] ctl;
  logic [31:0] sb [$];
  logic [31:0] mreg [32];
  logic [31:0] mcnt;
  int total = 0;
  int bad = 0;
  logic [74:0] tbl [20] = '{
    {32'hFFF00093, 32'hFFFFFFFF, 11'b0_1_0_0_0_0_1_0000},
    {32'hFE000EE3, 32'hFFFFFFFC, 11'b0_0_0_0_1_0_0_1000},
    {32'h40005093, 32'h00000400, 11'b0_1_0_0_0_0_1_1101},
    {32'h000012B7, 32'h00001000, 11'b0_1_0_0_0_0_1_0000},
    {32'h00112023, 32'h00000000, 11'b0_0_0_1_0_0_1_0000},
    {32'h008000EF, 32'h00000008, 11'b0_1_0_0_0_1_1_0000},
    {32'h40000033, 32'h00000000, 11'b0_1_0_0_0_0_0_1000},
    {32'h40005033, 32'h00000000, 11'b0_1_0_0_0_0_0_1101},
    {32'h40000013, 32'h00000400, 11'b0_1_0_0_0_0_1_0000},
    {32'h0FF07013, 32'h000000FF, 11'b0_1_0_0_0_0_1_0111},
    {32'hFFC02083, 32'hFFFFFFFC, 11'b0_1_1_0_0_0_1_0000},
    {32'h000080E7, 32'h00000000, 11'b0_1_0_0_0_1_1_0000},
    {32'h80000097, 32'h80000000, 11'b0_1_0_0_0_0_1_0000},
    {32'hFE112E23, 32'hFFFFFFFC, 11'b0_0_0_1_0_0_1_0000},
    {32'h00209463, 32'h00000008, 11'b0_0_0_0_1_0_0_1000},
    {32'hFFDFF0EF, 32'hFFFFFFFC, 11'b0_1_0_0_0_1_1_0000},
    {32'h0000007F, 32'h00000000, 11'b1_0_0_0_0_0_0_0000},
    {32'h00000000, 32'h00000000, 11'b1_0_0_0_0_0_0_0000},
    {32'h00005093, 32'h00000000, 11'b0_1_0_0_0_0_1_0101},
    {32'h00004033, 32'h00000000, 11'b0_1_0_0_0_0_0_0100}
  };
  decode_regfile dut (
    .clk(clk), .reset(reset), .instruction(instruction), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd), .imm(imm),
    .alu_ctrl(alu_ctrl), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .alu_src(alu_src), .illegal(illegal),
    .illegal_seen(illegal_seen), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  assign ctl = {illegal, reg_write, mem_read, mem_write, branch, jump, alu_src, alu_ctrl};
  function automatic logic legal_op(input logic [6:0] o);
    return o inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
  endfunction
  function automatic logic [31:0] rtype(input logic [4:0] s1, input logic [4:0] s2);
    return {7'b0, s2, s1, 3'b0, 5'd1, 7'h33};
  endfunction
  always @(posedge clk)
    if (!reset) mcnt <= '0;
    else if (legal_op(instruction[6:0])) mcnt <= mcnt + 32'd1;
  task automatic test_reset;
    logic [31:0] e;
    reset = 1'b0; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hA5A5A5A5; instruction = 32'h003181B3;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1; wb_en = 1'b0;
    sb.push_back(0); sb.push_back(0); sb.push_back(0); sb.push_back(0);
    #1;
    e = sb.pop_front(); total++; if (rs1_data !== e) begin bad++; $display("FAIL reset_rs1 got=%h exp=%h", rs1_data, e); end
    e = sb.pop_front(); total++; if (rs2_data !== e) begin bad++; $display("FAIL reset_rs2 got=%h exp=%h", rs2_data, e); end
    e = sb.pop_front(); total++; if (instr_count !== e) begin bad++; $display("FAIL reset_count got=%h exp=%h", instr_count, e); end
    e = sb.pop_front(); total++; if ({31'b0, illegal_seen} !== e) begin bad++; $display("FAIL reset_seen got=%h exp=%h", illegal_seen, e); end
  endtask
  task automatic test_regfile;
    logic [31:0] e;
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; instruction = 32'h00528133;
    sb.push_back(0); sb.push_back(0); sb.push_back(2);
    #1;
    e = sb.pop_front(); total++; if (rs1_data !== e) begin bad++; $display("FAIL old_rs1 got=%h exp=%h", rs1_data, e); end
    e = sb.pop_front(); total++; if (rs2_data !== e) begin bad++; $display("FAIL old_rs2 got=%h exp=%h", rs2_data, e); end
    e = sb.pop_front(); total++; if ({27'b0, rd} !== e) begin bad++; $display("FAIL rd got=%h exp=%h", rd, e); end
    @(negedge clk);
    wb_en = 1'b0;
    sb.push_back(32'hDEADBEEF); sb.push_back(32'hDEADBEEF);
    #1;
    e = sb.pop_front(); total++; if (rs1_data !== e) begin bad++; $display("FAIL new_rs1 got=%h exp=%h", rs1_data, e); end
    e = sb.pop_front(); total++; if (rs2_data !== e) begin bad++; $display("FAIL new_rs2 got=%h exp=%h", rs2_data, e); end
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234; instruction = 32'h00000033;
    @(negedge clk);
    wb_en = 1'b0;
    sb.push_back(0); sb.push_back(0);
    #1;
    e = sb.pop_front(); total++; if (rs1_data !== e) begin bad++; $display("FAIL x0_rs1 got=%h exp=%h", rs1_data, e); end
    e = sb.pop_front(); total++; if (rs2_data !== e) begin bad++; $display("FAIL x0_rs2 got=%h exp=%h", rs2_data, e); end
    mreg[0] = '0;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      mreg[i] = $urandom;
      wb_en = 1'b1; wb_addr = 5'(i); wb_data = mreg[i];
    end
    @(negedge clk);
    wb_en = 1'b0;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      instruction = rtype(5'(i), 5'(31 - i));
      sb.push_back(mreg[i]); sb.push_back(mreg[31 - i]);
      #1;
      e = sb.pop_front(); total++; if (rs1_data !== e) begin bad++; $display("FAIL rf_rs1[%0d] got=%h exp=%h", i, rs1_data, e); end
      e = sb.pop_front(); total++; if (rs2_data !== e) begin bad++; $display("FAIL rf_rs2[%0d] got=%h exp=%h", 31 - i, rs2_data, e); end
    end
    sb.push_back(mcnt);
    e = sb.pop_front(); total++; if (instr_count !== e) begin bad++; $display("FAIL rf_count got=%h exp=%h", instr_count, e); end
  endtask
  task automatic test_illegal;
    logic [31:0] e;
    @(negedge clk);
    instruction = 32'h00000013;
    sb.push_back(0);
    #1;
    e = sb.pop_front(); total++; if ({31'b0, illegal_seen} !== e) begin bad++; $display("FAIL seen_before got=%h exp=%h", illegal_seen, e); end
    @(negedge clk);
    instruction = 32'h0000007F;
    sb.push_back(1); sb.push_back(0); sb.push_back(0);
    #1;
    e = sb.pop_front(); total++; if ({31'b0, illegal} !== e) begin bad++; $display("FAIL illegal got=%h exp=%h", illegal, e); end
    e = sb.pop_front(); total++; if ({22'b0, ctl[9:0]} !== e) begin bad++; $display("FAIL illegal_ctl got=%h exp=%h", ctl[9:0], e); end
    e = sb.pop_front(); total++; if (imm !== e) begin bad++; $display("FAIL illegal_imm got=%h exp=%h", imm, e); end
    @(negedge clk);
    instruction = 32'h00000013;
    sb.push_back(1); sb.push_back(mcnt); sb.push_back(0);
    #1;
    e = sb.pop_front(); total++; if ({31'b0, illegal_seen} !== e) begin bad++; $display("FAIL seen_after got=%h exp=%h", illegal_seen, e); end
    e = sb.pop_front(); total++; if (instr_count !== e) begin bad++; $display("FAIL illegal_count got=%h exp=%h", instr_count, e); end
    e = sb.pop_front(); total++; if ({31'b0, illegal} !== e) begin bad++; $display("FAIL legal_again got=%h exp=%h", illegal, e); end
    repeat (3) @(negedge clk);
    sb.push_back(1);
    #1;
    e = sb.pop_front(); total++; if ({31'b0, illegal_seen} !== e) begin bad++; $display("FAIL seen_held got=%h exp=%h", illegal_seen, e); end
  endtask
  task automatic test_decode;
    logic [31:0] e;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      instruction = tbl[k][74:43];
      sb.push_back(tbl[k][42:11]); sb.push_back({21'b0, tbl[k][10:0]});
      #1;
      e = sb.pop_front();
      if (instruction[6:0] != 7'h33) begin
        total++; if (imm !== e) begin bad++; $display("FAIL imm[%0d] ins=%h got=%h exp=%h", k, instruction, imm, e); end
      end
      e = sb.pop_front(); total++; if ({21'b0, ctl} !== e) begin bad++; $display("FAIL ctl[%0d] ins=%h got=%b exp=%b", k, instruction, ctl, e[10:0]); end
    end
    @(negedge clk);
    instruction = 32'h00000013;
    sb.push_back(mcnt);
    #1;
    e = sb.pop_front(); total++; if (instr_count !== e) begin bad++; $display("FAIL decode_count got=%h exp=%h", instr_count, e); end
  endtask
  task automatic test_reset_write;
    logic [31:0] e;
    @(negedge clk);
    reset = 1'b0; wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h55; instruction = rtype(5'd7, 5'd5);
    @(negedge clk);
    reset = 1'b1; wb_en = 1'b0;
    sb.push_back(0); sb.push_back(0); sb.push_back(0); sb.push_back(0);
    #1;
    e = sb.pop_front(); total++; if (rs1_data !== e) begin bad++; $display("FAIL rst_wr_x7 got=%h exp=%h", rs1_data, e); end
    e = sb.pop_front(); total++; if (rs2_data !== e) begin bad++; $display("FAIL rst_clr_x5 got=%h exp=%h", rs2_data, e); end
    e = sb.pop_front(); total++; if ({31'b0, illegal_seen} !== e) begin bad++; $display("FAIL rst_seen got=%h exp=%h", illegal_seen, e); end
    e = sb.pop_front(); total++; if (instr_count !== e) begin bad++; $display("FAIL rst_count got=%h exp=%h", instr_count, e); end
  endtask
  task automatic test_wrap;
    logic [31:0] e;
    @(negedge clk);
    instruction = 32'h00000013;
    force dut.instr_count = 32'hFFFFFFFF;
    #1;
    release dut.instr_count;
    sb.push_back(32'hFFFFFFFF);
    e = sb.pop_front(); total++; if (instr_count !== e) begin bad++; $display("FAIL preload got=%h exp=%h", instr_count, e); end
    @(negedge clk);
    sb.push_back(0);
    #1;
    e = sb.pop_front(); total++; if (instr_count !== e) begin bad++; $display("FAIL wrap got=%h exp=%h", instr_count, e); end
    @(negedge clk);
    sb.push_back(1);
    #1;
    e = sb.pop_front(); total++; if (instr_count !== e) begin bad++; $display("FAIL post_wrap got=%h exp=%h", instr_count, e); end
  endtask
  initial begin
    test_reset;
    test_regfile;
    test_illegal;
    test_decode;
    test_reset_write;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
